// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel/line counters, per-axis phase FSMs, sync/blank
// pipeline matched to the PPU colour latency, and colour gating to the DAC.
//
// state     | meaning
// PH_ACTIVE | visible pixels (H) or visible lines (V)
// PH_FRONT  | front porch
// PH_SYNC   | sync pulse asserted
// PH_BACK   | back porch, returns to PH_ACTIVE on counter wrap
module vga_timing_generator #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   CLK_DIV     = 1,
  parameter int   PIXEL_DELAY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       colour_in,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_BEG = 10'(H_ACTIVE);
  localparam logic [9:0] H_SP_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_BP_BEG = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_BEG = 10'(V_ACTIVE);
  localparam logic [9:0] V_SP_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_BP_BEG = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  // Pipeline word: {hsync, vsync, display_on}
  localparam logic [2:0] PIPE_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  phase_t     h_phase, v_phase, h_phase_nx, v_phase_nx;
  logic [1:0] div_cnt, div_nx;
  logic [9:0] h_nx, v_nx;
  logic       h_wrap, v_wrap;
  logic [2:0] raw_nx;
  logic [2:0] pipe    [PIXEL_DELAY+1];
  logic [2:0] pipe_nx [PIXEL_DELAY+1];

  always_comb begin
    div_nx = (div_cnt == DIV_LAST) ? 2'd0 : div_cnt + 2'd1;
    h_wrap = pixel_tick && (counter_H == H_LAST);
    v_wrap = h_wrap && (counter_V == V_LAST);

    h_nx = counter_H;
    v_nx = counter_V;
    if (pixel_tick) h_nx = h_wrap ? 10'd0 : counter_H + 10'd1;
    if (h_wrap)     v_nx = v_wrap ? 10'd0 : counter_V + 10'd1;

    h_phase_nx = h_phase;
    if (pixel_tick) begin
      case (h_phase)
        PH_ACTIVE: if (h_nx == H_FP_BEG) h_phase_nx = PH_FRONT;
        PH_FRONT:  if (h_nx == H_SP_BEG) h_phase_nx = PH_SYNC;
        PH_SYNC:   if (h_nx == H_BP_BEG) h_phase_nx = PH_BACK;
        PH_BACK:   if (h_wrap)           h_phase_nx = PH_ACTIVE;
        default:                         h_phase_nx = PH_ACTIVE;
      endcase
    end

    v_phase_nx = v_phase;
    if (h_wrap) begin
      case (v_phase)
        PH_ACTIVE: if (v_nx == V_FP_BEG) v_phase_nx = PH_FRONT;
        PH_FRONT:  if (v_nx == V_SP_BEG) v_phase_nx = PH_SYNC;
        PH_SYNC:   if (v_nx == V_BP_BEG) v_phase_nx = PH_BACK;
        PH_BACK:   if (v_wrap)           v_phase_nx = PH_ACTIVE;
        default:                         v_phase_nx = PH_ACTIVE;
      endcase
    end

    raw_nx = {(h_phase_nx == PH_SYNC) ? SYNC_POL : ~SYNC_POL,
              (v_phase_nx == PH_SYNC) ? SYNC_POL : ~SYNC_POL,
              (h_phase_nx == PH_ACTIVE) && (v_phase_nx == PH_ACTIVE)};

    // Stage 0 follows the counters every clock so the first pixel after
    // reset release enters the pipeline; later stages only move on a tick.
    pipe_nx[0] = raw_nx;
    for (int i = 1; i <= PIXEL_DELAY; i++) begin
      pipe_nx[i] = pixel_tick ? pipe[i-1] : pipe[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt     <= 2'd0;
      pixel_tick  <= 1'b0;
      counter_H   <= 10'd0;
      counter_V   <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_phase     <= PH_ACTIVE;
      v_phase     <= PH_ACTIVE;
      for (int i = 0; i <= PIXEL_DELAY; i++) pipe[i] <= PIPE_IDLE;
      red         <= 2'b00;
      green       <= 2'b00;
      blue        <= 2'b00;
    end else begin
      div_cnt     <= div_nx;
      pixel_tick  <= (div_nx == DIV_LAST);
      counter_H   <= h_nx;
      counter_V   <= v_nx;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      h_phase     <= h_phase_nx;
      v_phase     <= v_phase_nx;
      for (int i = 0; i <= PIXEL_DELAY; i++) pipe[i] <= pipe_nx[i];
      // Gate with the blank value about to appear so colour and display_on change together.
      red         <= {2{colour_in & pipe_nx[PIXEL_DELAY][0]}};
      green       <= {2{colour_in & pipe_nx[PIXEL_DELAY][0]}};
      blue        <= {2{colour_in & pipe_nx[PIXEL_DELAY][0]}};
    end
  end

  assign hsync      = pipe[PIXEL_DELAY][2];
  assign vsync      = pipe[PIXEL_DELAY][1];
  assign display_on = pipe[PIXEL_DELAY][0];

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: full-size timing at two pipeline
// depths and CLK_DIV=2, plus a reduced geometry for frame-level behaviour.
module tb_vga_timing_generator;

  logic clk;
  logic reset_a, reset_s;
  logic colour_in;

  logic [9:0] p3_h, p3_v; logic p3_pt, p3_ls, p3_fs, p3_de, p3_hs, p3_vs; logic [1:0] p3_r, p3_g, p3_b;
  logic [9:0] p0_h, p0_v; logic p0_pt, p0_ls, p0_fs, p0_de, p0_hs, p0_vs; logic [1:0] p0_r, p0_g, p0_b;
  logic [9:0] d2_h, d2_v; logic d2_pt, d2_ls, d2_fs, d2_de, d2_hs, d2_vs; logic [1:0] d2_r, d2_g, d2_b;
  logic [9:0] sm_h, sm_v; logic sm_pt, sm_ls, sm_fs, sm_de, sm_hs, sm_vs; logic [1:0] sm_r, sm_g, sm_b;

  logic [5:0] p3_rgb, sm_rgb;
  assign p3_rgb = {p3_r, p3_g, p3_b};
  assign sm_rgb = {sm_r, sm_g, sm_b};

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_generator #(.PIXEL_DELAY(3)) u_p3 (
    .clk(clk), .reset(reset_a), .colour_in(colour_in),
    .counter_H(p3_h), .counter_V(p3_v), .pixel_tick(p3_pt), .line_start(p3_ls),
    .frame_start(p3_fs), .display_on(p3_de), .hsync(p3_hs), .vsync(p3_vs),
    .red(p3_r), .green(p3_g), .blue(p3_b));

  vga_timing_generator #(.PIXEL_DELAY(0)) u_p0 (
    .clk(clk), .reset(reset_a), .colour_in(colour_in),
    .counter_H(p0_h), .counter_V(p0_v), .pixel_tick(p0_pt), .line_start(p0_ls),
    .frame_start(p0_fs), .display_on(p0_de), .hsync(p0_hs), .vsync(p0_vs),
    .red(p0_r), .green(p0_g), .blue(p0_b));

  vga_timing_generator #(.CLK_DIV(2), .PIXEL_DELAY(0)) u_d2 (
    .clk(clk), .reset(reset_a), .colour_in(colour_in),
    .counter_H(d2_h), .counter_V(d2_v), .pixel_tick(d2_pt), .line_start(d2_ls),
    .frame_start(d2_fs), .display_on(d2_de), .hsync(d2_hs), .vsync(d2_vs),
    .red(d2_r), .green(d2_g), .blue(d2_b));

  // 24 x 11 raster: H sync at 18..20, V sync on lines 7..8
  vga_timing_generator #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIXEL_DELAY(2)) u_sm (
    .clk(clk), .reset(reset_s), .colour_in(colour_in),
    .counter_H(sm_h), .counter_V(sm_v), .pixel_tick(sm_pt), .line_start(sm_ls),
    .frame_start(sm_fs), .display_on(sm_de), .hsync(sm_hs), .vsync(sm_vs),
    .red(sm_r), .green(sm_g), .blue(sm_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_hs(input int x);
    return !(x >= 656 && x <= 751);
  endfunction

  initial begin
    int h, v, hd, n3;
    logic e3;
    int err_p3c = 0, err_p0c = 0, err_d2c = 0;
    int err_p0hs = 0, err_p0de = 0, err_p3de = 0, err_p3hs = 0, err_d2hs = 0, err_vs = 0;
    int p0_low = 0, p0_first_low = 0, d2_low = 0, d2_ticks = 0;
    int ls_cnt = 0, ls_first = 0, d2_ls_cnt = 0, d2_ls_k = 0, p3_fs_cnt = 0;
    int err_smc = 0, fs_cnt = 0, fs_first = 0, fs_second = 0, vs_low = 0, vs_first = 0;

    reset_a   = 1'b0;
    reset_s   = 1'b0;
    colour_in = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_h",      32'(p3_h),   32'd0);
    chk("rst_v",      32'(p3_v),   32'd0);
    chk("rst_hsync",  32'(p3_hs),  32'd1);
    chk("rst_vsync",  32'(p3_vs),  32'd1);
    chk("rst_de_p3",  32'(p3_de),  32'd0);
    chk("rst_de_p0",  32'(p0_de),  32'd0);
    chk("rst_rgb",    32'(p3_rgb), 32'd0);
    chk("rst_tick",   32'(p3_pt),  32'd0);
    chk("rst_ls",     32'(p0_ls),  32'd0);
    chk("rst_fs",     32'(p0_fs),  32'd0);

    colour_in = 1'b1;
    reset_a   = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      h  = (k - 1) % 800;
      v  = (k - 1) / 800;
      hd = k / 2;
      n3 = k - 4;
      e3 = (n3 >= 0) ? ((n3 % 800) < 640) : 1'b0;
      if (p3_h != 10'(h) || p3_v != 10'(v)) err_p3c++;
      if (p0_h != 10'(h) || p0_v != 10'(v)) err_p0c++;
      if (d2_h != 10'(hd % 800) || d2_v != 10'(hd / 800)) err_d2c++;
      if (p0_hs !== exp_hs(h)) err_p0hs++;
      if (p0_de !== (h < 640)) err_p0de++;
      if (p3_de !== e3 || p3_rgb !== (e3 ? 6'h3f : 6'h00)) err_p3de++;
      if (p3_hs !== ((n3 >= 0) ? exp_hs(n3 % 800) : 1'b1)) err_p3hs++;
      if (d2_hs !== exp_hs(hd % 800)) err_d2hs++;
      if (p3_vs !== 1'b1 || p0_vs !== 1'b1) err_vs++;
      if (!p0_hs) begin
        if (p0_first_low == 0) p0_first_low = k;
        p0_low++;
      end
      if (!d2_hs) d2_low++;
      if (d2_pt) d2_ticks++;
      if (p0_ls) begin
        ls_cnt++;
        if (ls_first == 0) ls_first = k;
      end
      if (d2_ls) begin
        d2_ls_cnt++;
        d2_ls_k = k;
      end
      if (p3_fs) p3_fs_cnt++;

      if (k == 1) begin
        chk("tick_after_release", 32'(p3_pt), 32'd1);
        chk("h_at_release",       32'(p3_h),  32'd0);
      end
      if (k == 6)   chk("h_after_5_ticks", 32'(p3_h),   32'd5);
      if (k == 3)   chk("rgb_h2",          32'(p3_rgb), 32'h00);
      if (k == 4)   chk("rgb_h3",          32'(p3_rgb), 32'h3f);
      if (k == 643) chk("rgb_h642",        32'(p3_rgb), 32'h3f);
      if (k == 644) chk("rgb_h643",        32'(p3_rgb), 32'h00);
      if (k == 800) chk("h_799",           32'(p0_h),   32'd799);
      if (k == 801) begin
        chk("h_wrap",     32'(p0_h),  32'd0);
        chk("v_inc",      32'(p0_v),  32'd1);
        chk("line_start", 32'(p0_ls), 32'd1);
      end
    end

    chk("p3_counters",    32'(err_p3c),      32'd0);
    chk("p0_counters",    32'(err_p0c),      32'd0);
    chk("d2_counters",    32'(err_d2c),      32'd0);
    chk("p0_hsync_shape", 32'(err_p0hs),     32'd0);
    chk("p0_de_shape",    32'(err_p0de),     32'd0);
    chk("p3_de_rgb",      32'(err_p3de),     32'd0);
    chk("p3_hsync_shape", 32'(err_p3hs),     32'd0);
    chk("d2_hsync_shape", 32'(err_d2hs),     32'd0);
    chk("vsync_idle",     32'(err_vs),       32'd0);
    chk("p0_hsync_first", 32'(p0_first_low), 32'd657);
    chk("p0_hsync_width", 32'(p0_low),       32'd192);
    chk("d2_hsync_width", 32'(d2_low),       32'd192);
    chk("d2_tick_count",  32'(d2_ticks),     32'd850);
    chk("p0_ls_count",    32'(ls_cnt),       32'd2);
    chk("p0_ls_first",    32'(ls_first),     32'd801);
    chk("d2_ls_count",    32'(d2_ls_cnt),    32'd1);
    chk("d2_line_len",    32'(d2_ls_k),      32'd1600);
    chk("p3_no_fs",       32'(p3_fs_cnt),    32'd0);

    reset_s = 1'b1;
    for (int k = 1; k <= 741; k++) begin
      @(negedge clk);
      h = (k - 1) % 24;
      v = ((k - 1) / 24) % 11;
      if (sm_h != 10'(h) || sm_v != 10'(v)) err_smc++;
      if (sm_fs) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = k;
        else if (fs_second == 0) fs_second = k;
      end
      if (k <= 264 && !sm_vs) begin
        vs_low++;
        if (vs_first == 0) vs_first = k;
      end
      if (k == 264) begin
        chk("sm_last_h", 32'(sm_h), 32'd23);
        chk("sm_last_v", 32'(sm_v), 32'd10);
      end
      if (k == 265) begin
        chk("sm_wrap_h", 32'(sm_h),  32'd0);
        chk("sm_wrap_v", 32'(sm_v),  32'd0);
        chk("sm_fs_on",  32'(sm_fs), 32'd1);
      end
      if (k == 266) chk("sm_fs_off", 32'(sm_fs), 32'd0);
    end

    chk("sm_counters",  32'(err_smc),             32'd0);
    chk("sm_fs_count",  32'(fs_cnt),              32'd2);
    chk("sm_fs_first",  32'(fs_first),            32'd265);
    chk("sm_frame_len", 32'(fs_second - fs_first), 32'd264);
    chk("sm_vs_first",  32'(vs_first),            32'd171);
    chk("sm_vs_width",  32'(vs_low),              32'd48);
    chk("sm_pre_h",     32'(sm_h),                32'd20);
    chk("sm_pre_v",     32'(sm_v),                32'd8);
    chk("sm_pre_hs",    32'(sm_hs),               32'd0);
    chk("sm_pre_vs",    32'(sm_vs),               32'd0);

    reset_s = 1'b0;
    @(negedge clk);
    chk("mid_rst_h",   32'(sm_h),   32'd0);
    chk("mid_rst_v",   32'(sm_v),   32'd0);
    chk("mid_rst_hs",  32'(sm_hs),  32'd1);
    chk("mid_rst_vs",  32'(sm_vs),  32'd1);
    chk("mid_rst_de",  32'(sm_de),  32'd0);
    chk("mid_rst_rgb", 32'(sm_rgb), 32'd0);
    chk("mid_rst_ls",  32'(sm_ls),  32'd0);
    chk("mid_rst_pt",  32'(sm_pt),  32'd0);

    reset_s = 1'b1;
    @(negedge clk);
    chk("restart_h0",  32'(sm_h),  32'd0);
    chk("restart_de0", 32'(sm_de), 32'd0);
    @(negedge clk);
    chk("restart_de1", 32'(sm_de), 32'd0);
    @(negedge clk);
    chk("restart_h2",  32'(sm_h),   32'd2);
    chk("restart_de2", 32'(sm_de),  32'd1);
    chk("restart_rgb", 32'(sm_rgb), 32'h3f);

    colour_in = 1'b0;
    @(negedge clk);
    chk("black_rgb", 32'(sm_rgb), 32'd0);
    chk("black_de",  32'(sm_de),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
